// File: rtl/afe_l2_ring_reader.sv
// Per-channel L2 ring-buffer reader: single-beat L2 reads
// chasing the writer pointer, delivered through a 2-entry stream FIFO.
module afe_l2_ring_reader #(
  parameter int unsigned AWIDTH     = 18,
  parameter int unsigned TRANS_SIZE = 16,
  parameter int unsigned DWIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [AWIDTH-1:0]     cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_clr_i,
  input  logic [TRANS_SIZE-1:0] wr_ptr_i,
  output logic [TRANS_SIZE-1:0] cfg_rd_ptr_o,
  output logic [TRANS_SIZE-1:0] cfg_bytes_avail_o,
  output logic                  cfg_en_o,
  output logic                  l2_req_o,
  output logic [AWIDTH-1:0]     l2_addr_o,
  input  logic                  l2_gnt_i,
  input  logic                  l2_rvalid_i,
  input  logic [DWIDTH-1:0]     l2_rdata_i,
  output logic [DWIDTH-1:0]     data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  wrap_event_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  en_q, en_d;
  logic [TRANS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  wrap_q, wrap_d;

  logic [DWIDTH-1:0]     mem_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q;

  logic                  en_set, clr_eff;
  logic                  start, grant, rdone;
  logic                  adv, wraps, push, pop;
  logic [TRANS_SIZE-1:0] avail, ptr_inc;

  assign en_set  = cfg_en_i & ~en_q;
  assign clr_eff = cfg_clr_i & ~en_set;

  always_comb begin
    avail = '0;
    if (en_q) begin
      if (wr_ptr_i >= rd_ptr_q)
        avail = wr_ptr_i - rd_ptr_q;
      else
        avail = wr_ptr_i + cfg_size_i - rd_ptr_q;
    end
  end

  assign start = (state_q == S_IDLE) & en_q
               & (avail >= TRANS_SIZE'(4))
               & (cnt_q <= 2'd1) & ~cfg_clr_i;
  assign grant = (state_q == S_REQ) & l2_gnt_i;
  assign rdone = (state_q == S_WAIT) & l2_rvalid_i;

  assign ptr_inc = rd_ptr_q + TRANS_SIZE'(4);
  assign wraps   = ptr_inc >= cfg_size_i;

  // A grant that belongs to a cleared transfer must not move the pointer
  assign adv  = grant & ~discard_q & ~clr_eff & ~en_set;
  assign push = rdone & ~discard_q & ~clr_eff;
  assign pop  = (cnt_q != 2'd0) & ready_i & ~clr_eff;

  always_comb begin
    en_d     = en_q;
    rd_ptr_d = rd_ptr_q;
    wrap_d   = 1'b0;
    if (en_set) begin
      en_d     = 1'b1;
      rd_ptr_d = '0;
    end else if (cfg_clr_i) begin
      en_d     = 1'b0;
      rd_ptr_d = '0;
    end else if (adv) begin
      rd_ptr_d = wraps ? '0 : ptr_inc;
      wrap_d   = wraps;
    end
  end

  always_comb begin
    discard_d = discard_q;
    if (rdone)
      discard_d = 1'b0;
    if (clr_eff && ((state_q == S_REQ) ||
        ((state_q == S_WAIT) && !l2_rvalid_i)))
      discard_d = 1'b1;
  end

  assign addr_d = start ? cfg_startaddr_i + AWIDTH'(rd_ptr_q)
                        : addr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (l2_gnt_i) state_d = S_WAIT;
      S_WAIT: if (l2_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    l2_req_o = (state_q == S_REQ);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q      <= 1'b0;
      rd_ptr_q  <= '0;
      addr_q    <= '0;
      discard_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      wrap_q    <= wrap_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr_eff) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= l2_rdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop)
        rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign cfg_rd_ptr_o      = rd_ptr_q;
  assign cfg_bytes_avail_o = avail;
  assign cfg_en_o          = en_q;
  assign l2_addr_o         = addr_q;
  assign data_o            = mem_q[rptr_q];
  assign valid_o           = (cnt_q != 2'd0);
  assign wrap_event_o      = wrap_q;

endmodule

// File: tb/tb_afe_l2_ring_reader.sv
// Directed bench for afe_l2_ring_reader with a small L2 responder
// and directed/table vectors.
module tb_afe_l2_ring_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic [17:0] startaddr;
  logic [15:0] size;
  logic        en, clr;
  logic [15:0] wr;
  logic [15:0] rd_ptr, avail;
  logic        en_o, req;
  logic [17:0] addr;
  logic        gnt, rvalid;
  logic [31:0] rdata, data;
  logic        valid, ready, wrap;

  afe_l2_ring_reader dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .cfg_startaddr_i   (startaddr),
    .cfg_size_i        (size),
    .cfg_en_i          (en),
    .cfg_clr_i         (clr),
    .wr_ptr_i          (wr),
    .cfg_rd_ptr_o      (rd_ptr),
    .cfg_bytes_avail_o (avail),
    .cfg_en_o          (en_o),
    .l2_req_o          (req),
    .l2_addr_o         (addr),
    .l2_gnt_i          (gnt),
    .l2_rvalid_i       (rvalid),
    .l2_rdata_i        (rdata),
    .data_o            (data),
    .valid_o           (valid),
    .ready_i           (ready),
    .wrap_event_o      (wrap)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  function automatic logic [31:0] word(input logic [17:0] a);
    return 32'hD000_0000 | {14'd0, a};
  endfunction

  // L2 responder
  int          gnt_delay = 0;
  int          rv_lat    = 1;
  bit          gnt_block = 1'b0;
  int          wcnt      = 0;
  int          rv_cnt    = 0;
  logic [17:0] rv_addr   = '0;

  initial begin
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rdata  = '0;
      gnt    = 1'b0;
      if (!rstn) begin
        wcnt   = 0;
        rv_cnt = 0;
      end else begin
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = word(rv_addr);
          end
        end
        if (req && !gnt_block) begin
          if (wcnt >= gnt_delay) begin
            gnt     = 1'b1;
            rv_addr = addr;
            rv_cnt  = rv_lat;
            wcnt    = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Observers
  int          cyc = 0;
  logic [17:0] gq[$];
  int          gcyc[$];
  int          wq[$];
  logic [31:0] outq[$];
  int          req_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (req && gnt) begin
        gq.push_back(addr);
        gcyc.push_back(cyc);
      end
      if (wrap) wq.push_back(cyc);
      if (valid && ready) outq.push_back(data);
      if (req) req_cnt++;
    end
  end

  function automatic logic [31:0] ga(input int i);
    return (i < gq.size()) ? {14'd0, gq[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] oa(input int i);
    return (i < outq.size()) ? outq[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_words(input int n, input int budget,
                            input string nm);
    for (int k = 0; k < budget && outq.size() < n; k++)
      @(negedge clk);
    chk(nm, outq.size(), n);
  endtask

  typedef struct {
    logic [15:0] wr;
    logic [15:0] avail;
    logic        req;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          n0, n1, o1, rc0, wc, gc;
    logic [31:0] d0;
    bit          stable, held, found;

    vecs[0] = '{16'd20, 16'd0,  1'b0};
    vecs[1] = '{16'd24, 16'd4,  1'b1};
    vecs[2] = '{16'd28, 16'd8,  1'b1};
    vecs[3] = '{16'd0,  16'd12, 1'b1};
    vecs[4] = '{16'd16, 16'd28, 1'b1};
    vecs[5] = '{16'd4,  16'd16, 1'b1};
    vecs[6] = '{16'd20, 16'd0,  1'b1};

    rstn      = 1'b0;
    startaddr = 18'h1000;
    size      = 16'd16;
    en        = 1'b0;
    clr       = 1'b0;
    wr        = '0;
    ready     = 1'b1;

    nclk(2);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_en",     en_o,   0);
    chk("rst_req",    req,    0);
    chk("rst_addr",   addr,   0);
    chk("rst_valid",  valid,  0);
    chk("rst_data",   data,   0);
    chk("rst_wrap",   wrap,   0);
    chk("rst_avail",  avail,  0);

    tick();
    rstn = 1'b1;

    // Two words from the start of the buffer
    tick(); en = 1'b1;
    tick(); en = 1'b0;
    @(negedge clk);
    chk("t1_en", en_o, 1);
    chk("t1_ptr0", rd_ptr, 0);
    tick(); wr = 16'd8;
    wait_words(2, 40, "t1_words");
    nclk(3);
    chk("t1_ngnt", gq.size(), 2);
    chk("t1_a0", ga(0), 32'h1000);
    chk("t1_a1", ga(1), 32'h1004);
    chk("t1_d0", oa(0), 32'hD000_1000);
    chk("t1_d1", oa(1), 32'hD000_1004);
    chk("t1_ptr", rd_ptr, 8);
    chk("t1_avail", avail, 0);
    chk("t1_req", req, 0);

    // Wrap from 0x100C back to the base
    tick(); wr = 16'd12;
    wait_words(3, 40, "t2_pre");
    nclk(2);
    chk("t2_ptr12", rd_ptr, 12);
    wq.delete();
    tick(); wr = 16'd4;
    @(negedge clk);
    chk("t2_avail", avail, 8);
    wait_words(5, 40, "t2_words");
    nclk(3);
    chk("t2_a3", ga(3), 32'h100C);
    chk("t2_a4", ga(4), 32'h1000);
    chk("t2_d3", oa(3), 32'hD000_100C);
    chk("t2_d4", oa(4), 32'hD000_1000);
    chk("t2_nwrap", wq.size(), 1);
    wc = (wq.size() > 0) ? wq[0] : -1;
    gc = (gcyc.size() > 3) ? gcyc[3] + 1 : -2;
    chk("t2_wrap_cyc", wc, gc);
    chk("t2_ptr", rd_ptr, 4);

    // Backpressure: six words available, FIFO holds two
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    size  = 16'd32;
    wr    = 16'd0;
    ready = 1'b0;
    outq.delete();
    gq.delete();
    gcyc.delete();
    tick(); en = 1'b1;
    tick(); en = 1'b0;
    tick(); wr = 16'd24;
    nclk(30);
    chk("t3_ngnt", gq.size(), 2);
    chk("t3_valid", valid, 1);
    chk("t3_head", data, 32'hD000_1000);
    chk("t3_req", req, 0);
    chk("t3_ptr", rd_ptr, 8);
    chk("t3_avail", avail, 16);
    d0     = data;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!valid || data !== d0) stable = 1'b0;
    end
    chk("t3_stable", stable, 1);
    tick(); ready = 1'b1;
    wait_words(6, 60, "t3_words");
    nclk(2);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_d%0d", i), oa(i), 32'hD000_1000 + 4 * i);
    chk("t3_ptr24", rd_ptr, 24);
    chk("t3_avail0", avail, 0);

    // Grant delayed by three cycles
    gnt_delay = 3;
    tick(); wr = 16'd28;
    @(negedge clk);
    for (int k = 0; k < 10 && !req; k++) @(negedge clk);
    held = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!(req && addr == 18'h1018 && rd_ptr == 16'd24 && !gnt))
        held = 1'b0;
      @(negedge clk);
    end
    chk("t4_held", held, 1);
    chk("t4_gnt", gnt, 1);
    chk("t4_ptr_gnt", rd_ptr, 24);
    @(negedge clk);
    chk("t4_ptr_adv", rd_ptr, 28);
    gnt_delay = 0;
    wait_words(7, 20, "t4_word");
    chk("t4_d", oa(6), 32'hD000_1018);

    // Clear while the read data is still outstanding
    rv_lat = 3;
    n0     = gq.size();
    tick(); wr = 16'd0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (req && gnt) found = 1'b1;
    end
    chk("t5_gnt_seen", found, 1);
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    rc0 = req_cnt;
    nclk(10);
    chk("t5_nout", outq.size(), 7);
    chk("t5_valid", valid, 0);
    chk("t5_en", en_o, 0);
    chk("t5_ptr", rd_ptr, 0);
    chk("t5_ngnt", gq.size(), n0 + 1);
    chk("t5_noreq", req_cnt, rc0);
    rv_lat = 1;

    // Enable wins over a simultaneous clear
    tick(); en = 1'b1; clr = 1'b1;
    tick(); en = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("t6_en", en_o, 1);
    chk("t6_ptr", rd_ptr, 0);
    chk("t6_avail", avail, 0);

    // Fill-level table with the reader parked at offset 20
    tick(); wr = 16'd20;
    wait_words(12, 80, "tv_pre");
    nclk(2);
    chk("tv_ptr20", rd_ptr, 20);
    gnt_block = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); wr = vecs[i].wr;
      nclk(2);
      chk($sformatf("tv%0d_avail", i), avail, vecs[i].avail);
      chk($sformatf("tv%0d_req", i), req, vecs[i].req);
    end
    chk("tv_addr", addr, 32'h1014);

    // Clear while the request still waits for its grant
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
    chk("tc_req_held", req, 1);
    chk("tc_addr_held", addr, 32'h1014);
    chk("tc_en", en_o, 0);
    chk("tc_avail", avail, 0);
    n1 = gq.size();
    o1 = outq.size();
    gnt_block = 1'b0;
    nclk(8);
    chk("tc_ngnt", gq.size(), n1 + 1);
    chk("tc_nout", outq.size(), o1);
    chk("tc_req", req, 0);
    chk("tc_valid", valid, 0);
    chk("tc_ptr", rd_ptr, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
